id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard detection and bubble insertion.
- Captures decoded operands and control from ID and presents the registered ID_EX_* fields to EX.
- Its ID_EX_RegRs and ID_EX_RegRt are the operand-select inputs of the forwarding unit.
- Drives the stall that freezes PC and IF/ID, and keeps saturating stall/bubble performance counters.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: widths and ALU operation encodings shared by the ID, EX and ID/EX stages.
// Rev 1.0
`default_nettype none

package pipe_pkg;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  // Op loaded on reset and into bubbles; harmless because RegWrite/MemWrite are cleared too.
  localparam alu_op_e ALUOP_NOP = ALU_ADD;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard term between the load in EX and the instruction in ID.
// Rev 1.0
`default_nettype none

module load_use_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             ex_mem_read_i,
  input  logic             ex_valid_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_o
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (ex_rd_i == id_rs_i);
  assign w_rt_match = id_uses_rt_i && (ex_rd_i == id_rt_i);

  // A load targeting $0 never produces a value worth waiting for.
  assign lu_o = ex_mem_read_i && ex_valid_i && id_valid_i &&
                (ex_rd_i != '0) && (w_rs_match || w_rt_match);

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion and saturating perf counters.
// Rev 1.0
`default_nettype none

module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   ID_RegRs,
  input  logic [REG_W-1:0]   ID_RegRt,
  input  logic [REG_W-1:0]   ID_RegRd,
  input  logic               ID_UsesRt,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_Valid,
  input  logic               Flush,
  input  logic               Hold,
  output logic               Stall,
  output logic [REG_W-1:0]   ID_EX_RegRs,
  output logic [REG_W-1:0]   ID_EX_RegRt,
  output logic [REG_W-1:0]   ID_EX_RegRd,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [DATA_W-1:0]  ID_EX_ReadData1,
  output logic [DATA_W-1:0]  ID_EX_ReadData2,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic               ID_EX_Valid,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   BubbleCount
);

  logic [REG_W-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic               reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic               alu_src_q, alu_src_d, valid_q, valid_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [CNT_W-1:0]   stall_cnt_q, bubble_cnt_q;
  logic               w_lu;
  logic               w_bubble;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .ex_mem_read_i (mem_read_q),
    .ex_valid_i    (valid_q),
    .ex_rd_i       (rd_q),
    .id_valid_i    (ID_Valid),
    .id_rs_i       (ID_RegRs),
    .id_rt_i       (ID_RegRt),
    .id_uses_rt_i  (ID_UsesRt),
    .lu_o          (w_lu)
  );

  // A squashed ID instruction does not need to wait for the load.
  assign Stall    = w_lu && !Flush && !reset;
  assign w_bubble = !Hold && (Flush || w_lu);

  always_comb begin
    rs_d = rs_q;  rt_d = rt_q;  rd_d = rd_q;
    reg_write_d = reg_write_q;  mem_read_d = mem_read_q;
    mem_write_d = mem_write_q;  mem_to_reg_d = mem_to_reg_q;
    alu_src_d = alu_src_q;  alu_op_d = alu_op_q;  valid_d = valid_q;
    rd1_d = rd1_q;  rd2_d = rd2_q;  imm_d = imm_q;
    if (w_bubble) begin
      // Clearing rd keeps the forwarding unit from matching a bubble.
      rs_d = '0;  rt_d = '0;  rd_d = '0;
      reg_write_d = 1'b0;  mem_read_d = 1'b0;
      mem_write_d = 1'b0;  mem_to_reg_d = 1'b0;
      alu_src_d = 1'b0;  alu_op_d = ALUOP_W'(ALUOP_NOP);  valid_d = 1'b0;
      rd1_d = '0;  rd2_d = '0;  imm_d = '0;
    end else if (!Hold) begin
      rs_d = ID_RegRs;  rt_d = ID_RegRt;  rd_d = ID_RegRd;
      reg_write_d = ID_RegWrite;  mem_read_d = ID_MemRead;
      mem_write_d = ID_MemWrite;  mem_to_reg_d = ID_MemtoReg;
      alu_src_d = ID_ALUSrc;  alu_op_d = ID_ALUOp;  valid_d = ID_Valid;
      rd1_d = ID_ReadData1;  rd2_d = ID_ReadData2;  imm_d = ID_Imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q <= '0;  rt_q <= '0;  rd_q <= '0;
      reg_write_q <= 1'b0;  mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;  mem_to_reg_q <= 1'b0;
      alu_src_q <= 1'b0;  alu_op_q <= ALUOP_W'(ALUOP_NOP);  valid_q <= 1'b0;
      rd1_q <= '0;  rd2_q <= '0;  imm_q <= '0;
    end else begin
      rs_q <= rs_d;  rt_q <= rt_d;  rd_q <= rd_d;
      reg_write_q <= reg_write_d;  mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;  mem_to_reg_q <= mem_to_reg_d;
      alu_src_q <= alu_src_d;  alu_op_q <= alu_op_d;  valid_q <= valid_d;
      rd1_q <= rd1_d;  rd2_q <= rd2_d;  imm_q <= imm_d;
    end
  end

  // Stall cycles are counted even while Hold freezes the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (Stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (w_bubble && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign ID_EX_RegRs     = rs_q;
  assign ID_EX_RegRt     = rt_q;
  assign ID_EX_RegRd     = rd_q;
  assign ID_EX_RegWrite  = reg_write_q;
  assign ID_EX_MemRead   = mem_read_q;
  assign ID_EX_MemWrite  = mem_write_q;
  assign ID_EX_MemtoReg  = mem_to_reg_q;
  assign ID_EX_ALUSrc    = alu_src_q;
  assign ID_EX_ALUOp     = alu_op_q;
  assign ID_EX_ReadData1 = rd1_q;
  assign ID_EX_ReadData2 = rd2_q;
  assign ID_EX_Imm       = imm_q;
  assign ID_EX_Valid     = valid_q;
  assign StallCount      = stall_cnt_q;
  assign BubbleCount     = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench with a reference model feeding an expected-result queue.
// Rev 1.0
`default_nettype none

module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int SAT_W = 3;

  logic        clk = 1'b0;
  logic        reset, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Valid, Flush, Hold;
  logic [4:0]  ID_RegRs, ID_RegRt, ID_RegRd;
  logic [3:0]  ID_ALUOp;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;

  logic        Stall, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Valid;
  logic [4:0]  ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd;
  logic [3:0]  ID_EX_ALUOp;
  logic [31:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm;
  logic [15:0] StallCount, BubbleCount;

  logic        s_Stall, s_RegWrite, s_MemRead, s_MemWrite, s_MemtoReg, s_ALUSrc, s_Valid;
  logic [4:0]  s_RegRs, s_RegRt, s_RegRd;
  logic [3:0]  s_ALUOp;
  logic [31:0] s_ReadData1, s_ReadData2, s_Imm;
  logic [SAT_W-1:0] s_StallCount, s_BubbleCount;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_RegRd(ID_RegRd),
    .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1),
    .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_Valid(ID_Valid), .Flush(Flush), .Hold(Hold),
    .Stall(Stall), .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRt(ID_EX_RegRt), .ID_EX_RegRd(ID_EX_RegRd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_MemWrite(ID_EX_MemWrite),
    .ID_EX_MemtoReg(ID_EX_MemtoReg), .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2), .ID_EX_Imm(ID_EX_Imm),
    .ID_EX_Valid(ID_EX_Valid), .StallCount(StallCount), .BubbleCount(BubbleCount)
  );

  // Narrow-counter copy: shows saturation without tens of thousands of cycles.
  id_ex_stage #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset(reset), .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_RegRd(ID_RegRd),
    .ID_UsesRt(ID_UsesRt), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1),
    .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm), .ID_Valid(ID_Valid), .Flush(Flush), .Hold(Hold),
    .Stall(s_Stall), .ID_EX_RegRs(s_RegRs), .ID_EX_RegRt(s_RegRt), .ID_EX_RegRd(s_RegRd),
    .ID_EX_RegWrite(s_RegWrite), .ID_EX_MemRead(s_MemRead), .ID_EX_MemWrite(s_MemWrite),
    .ID_EX_MemtoReg(s_MemtoReg), .ID_EX_ALUSrc(s_ALUSrc), .ID_EX_ALUOp(s_ALUOp),
    .ID_EX_ReadData1(s_ReadData1), .ID_EX_ReadData2(s_ReadData2), .ID_EX_Imm(s_Imm),
    .ID_EX_Valid(s_Valid), .StallCount(s_StallCount), .BubbleCount(s_BubbleCount)
  );

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw, m2r, als;
    logic [3:0]  op;
    logic [31:0] d1, d2, imm;
    logic        v;
  } ex_t;

  typedef struct {
    ex_t         ex;
    logic        chk_data;
    logic [15:0] sc, bc;
  } exp_t;

  exp_t        sb_q[$];
  ex_t         m;
  logic        m_chk;
  logic [15:0] m_sc, m_bc;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        obs_stall;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, rt, rd, input logic uses_rt, rw, mr, mw, m2r, als,
                        input logic [3:0] op, input logic [31:0] d1, d2, imm, input logic v);
    ID_RegRs = rs; ID_RegRt = rt; ID_RegRd = rd; ID_UsesRt = uses_rt;
    ID_RegWrite = rw; ID_MemRead = mr; ID_MemWrite = mw; ID_MemtoReg = m2r; ID_ALUSrc = als;
    ID_ALUOp = op; ID_ReadData1 = d1; ID_ReadData2 = d2; ID_Imm = imm; ID_Valid = v;
  endtask

  task automatic lw8();
    set_id(5'd1, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD, 32'h1000, 32'h0, 32'h4, 1'b1);
  endtask

  task automatic add_rs8();
    set_id(5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 1'b1);
  endtask

  // One clock: check Stall against the model, push the model's next state, compare after the edge.
  task automatic tick();
    exp_t e;
    logic lu, es;
    #1;
    lu = m.mr & m.v & ID_Valid & (m.rd != 5'd0) &
         ((m.rd == ID_RegRs) | (ID_UsesRt & (m.rd == ID_RegRt)));
    es = lu & ~Flush & ~reset;
    obs_stall = Stall;
    check("stall", Stall, es);
    if (reset) begin
      m = '0; m_chk = 1'b1; m_sc = '0; m_bc = '0;
    end else begin
      if (es && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (!Hold) begin
        if (Flush || lu) begin
          m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.v = 0; m.rd = '0;
          m_chk = 1'b0;
          if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
        end else begin
          m = '{ID_RegRs, ID_RegRt, ID_RegRd, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg,
                ID_ALUSrc, ID_ALUOp, ID_ReadData1, ID_ReadData2, ID_Imm, ID_Valid};
          m_chk = 1'b1;
        end
      end
    end
    e.ex = m; e.chk_data = m_chk; e.sc = m_sc; e.bc = m_bc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("ctrl", {ID_EX_RegRd, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_Valid},
                  {e.ex.rd, e.ex.rw, e.ex.mr, e.ex.mw, e.ex.m2r, e.ex.v});
    if (e.chk_data)
      check("data", {ID_EX_RegRs, ID_EX_RegRt, ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm},
                    {e.ex.rs, e.ex.rt, e.ex.als, e.ex.op, e.ex.d1, e.ex.d2, e.ex.imm});
    check("stall_cnt", StallCount, e.sc);
    check("bubble_cnt", BubbleCount, e.bc);
    check("sat_stall_cnt", s_StallCount, (e.sc > 16'd7) ? 3'd7 : e.sc[2:0]);
    check("sat_bubble_cnt", s_BubbleCount, (e.bc > 16'd7) ? 3'd7 : e.bc[2:0]);
  endtask

  initial begin
    m = '0; m_chk = 1'b1; m_sc = '0; m_bc = '0;

    // Reset overrides Hold and Flush with a busy ID bus.
    reset = 1'b1; Hold = 1'b1; Flush = 1'b1;
    set_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ALU_XOR, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFF0, 1'b1);
    tick();
    check("rst_stall", obs_stall, 1'b0);
    check("rst_all", {ID_EX_RegRs, ID_EX_Valid, ID_EX_ReadData1, StallCount, BubbleCount}, '0);
    reset = 1'b0; Hold = 1'b0; Flush = 1'b0;

    // Load-use on rs: one bubble, dependent enters EX on the next edge.
    lw8(); tick();
    add_rs8(); tick();
    check("lu_stall", obs_stall, 1'b1);
    check("lu_bubble", {ID_EX_RegWrite, ID_EX_RegRd, ID_EX_Valid, BubbleCount}, {1'b0, 5'd0, 1'b0, 16'd1});
    tick();
    check("lu_dep", {ID_EX_RegRs, ID_EX_Valid, StallCount}, {5'd8, 1'b1, 16'd1});

    // rt match without UsesRt: no hazard.
    lw8(); tick();
    set_id(5'd3, 5'd8, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR, 32'h11, 32'h22, 32'h33, 1'b1);
    tick();
    check("rt_nouse", {obs_stall, ID_EX_RegRt, ID_EX_Valid}, {1'b0, 5'd8, 1'b1});

    // Load to $0 never stalls.
    set_id(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD, 32'h40, 32'h0, 32'h8, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_AND, 32'h5, 32'h6, 32'h0, 1'b1);
    tick();
    check("r0_nostall", {obs_stall, ID_EX_Valid, ID_EX_RegRd}, {1'b0, 1'b1, 5'd12});

    // Flush masks the stall and still bubbles.
    lw8(); tick();
    add_rs8(); Flush = 1'b1; tick();
    check("flush_lu", {obs_stall, ID_EX_Valid, BubbleCount}, {1'b0, 1'b0, 16'd2});
    Flush = 1'b0;

    // Hold during load-use: frozen, stalls counted, one bubble on release.
    lw8(); tick();
    add_rs8(); Hold = 1'b1;
    tick(); tick(); tick();
    check("hold_frozen", {ID_EX_MemRead, ID_EX_RegRd, ID_EX_Valid}, {1'b1, 5'd8, 1'b1});
    check("hold_cnts", {StallCount, BubbleCount}, {16'd4, 16'd2});
    Hold = 1'b0; tick();
    check("hold_release", {ID_EX_Valid, StallCount, BubbleCount}, {1'b0, 16'd5, 16'd3});
    tick();
    check("hold_dep", {ID_EX_Valid, ID_EX_RegRs}, {1'b1, 5'd8});

    // Hold and Flush together: Hold wins, Flush applies once Hold drops.
    Hold = 1'b1; Flush = 1'b1; tick();
    check("hf_hold", {ID_EX_Valid, BubbleCount}, {1'b1, 16'd3});
    Hold = 1'b0; tick();
    check("hf_flush", {ID_EX_Valid, BubbleCount}, {1'b0, 16'd4});

    // Saturation on the narrow copy.
    repeat (5) tick();
    check("sat_bubble", {s_BubbleCount, BubbleCount}, {3'd7, 16'd9});
    Flush = 1'b0;
    lw8(); tick();
    add_rs8(); Hold = 1'b1;
    repeat (3) tick();
    check("sat_stall", {s_StallCount, StallCount}, {3'd7, 16'd8});

    // Reset in the middle of a held stall.
    reset = 1'b1; tick();
    check("rst_mid", {obs_stall, ID_EX_Valid, StallCount, BubbleCount}, {1'b0, 1'b0, 16'd0, 16'd0});
    reset = 1'b0; Hold = 1'b0; tick();
    check("restart", {ID_EX_Valid, ID_EX_RegRs, StallCount}, {1'b1, 5'd8, 16'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, elapsed %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
